// File: rtl/pipe_exc_ctrl.sv
// pipe_exc_ctrl: exception and halt sequencer for the five-stage pipeline.
// Watches the ID illegal-opcode and HALT flags and the EX overflow flag.
// Drives the stage flush lines, the PC write-enable and the PC redirect.
// Captures EPC and Cause for the handler.
// Optional feature macro: PIPE_EXC_COUNT_EN adds an 8-bit saturating
// exception counter on output port exc_count.

module pipe_exc_ctrl #(
    parameter int              PC_W         = 16,
    parameter logic [PC_W-1:0] VEC_ILLEGAL  = 16'h8000,
    parameter logic [PC_W-1:0] VEC_OVF      = 16'h8010,
    parameter int              DRAIN_CYCLES = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_illegal,
    input  logic            id_halt,
    input  logic [PC_W-1:0] id_pc,
    input  logic            ex_overflow,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            resume,
    output logic            if_flush,
    output logic            id_flush,
    output logic            ex_flush,
    output logic            pc_write_en,
    output logic            pc_redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic [1:0]      cause,
`ifdef PIPE_EXC_COUNT_EN
    output logic [7:0]      exc_count,
`endif
    output logic            halted
);

    // Wide enough to hold DRAIN_CYCLES-1, never narrower than one bit.
    localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_OVF     = 2'b10;
    localparam logic [1:0] CAUSE_HALT    = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_REDIRECT,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   epc_reg, epc_next;
    logic [PC_W-1:0]   redirect_pc_reg, redirect_pc_next;
    logic [1:0]        cause_reg, cause_next;
    logic              halted_reg, halted_next;
    logic [CNT_W-1:0]  drain_cnt_reg, drain_cnt_next;

    logic              if_flush_comb;
    logic              id_flush_comb;
    logic              ex_flush_comb;
    logic              pc_write_en_comb;
    logic              pc_redirect_comb;

    // Next-state logic and the combinational flush/stall controls.
    always_comb begin
        state_next       = state_reg;
        epc_next         = epc_reg;
        redirect_pc_next = redirect_pc_reg;
        cause_next       = cause_reg;
        halted_next      = halted_reg;
        drain_cnt_next   = drain_cnt_reg;
        if_flush_comb    = 1'b0;
        id_flush_comb    = 1'b0;
        ex_flush_comb    = 1'b0;
        pc_write_en_comb = 1'b1;
        pc_redirect_comb = 1'b0;

        case (state_reg)
            ST_RUN: begin
                // Overflow belongs to the older instruction, so it wins.
                if (ex_overflow) begin
                    if_flush_comb    = 1'b1;
                    id_flush_comb    = 1'b1;
                    ex_flush_comb    = 1'b1;
                    epc_next         = ex_pc;
                    cause_next       = CAUSE_OVF;
                    redirect_pc_next = VEC_OVF;
                    state_next       = ST_REDIRECT;
                end else if (id_illegal) begin
                    if_flush_comb    = 1'b1;
                    id_flush_comb    = 1'b1;
                    epc_next         = id_pc;
                    cause_next       = CAUSE_ILLEGAL;
                    redirect_pc_next = VEC_ILLEGAL;
                    state_next       = ST_REDIRECT;
                end else if (id_halt) begin
                    if_flush_comb    = 1'b1;
                    id_flush_comb    = 1'b1;
                    pc_write_en_comb = 1'b0;
                    epc_next         = id_pc;
                    cause_next       = CAUSE_HALT;
                    drain_cnt_next   = DRAIN_LOAD;
                    state_next       = ST_DRAIN;
                end
            end

            ST_REDIRECT: begin
                // The excepting instruction is already flushed; a new
                // overflow flag here is stale and is ignored.
                pc_redirect_comb = 1'b1;
                if_flush_comb    = 1'b1;
                state_next       = ST_RUN;
            end

            ST_DRAIN: begin
                pc_write_en_comb = 1'b0;
                if_flush_comb    = 1'b1;
                if (ex_overflow) begin
                    // An older instruction faulted: abandon the halt.
                    pc_write_en_comb = 1'b1;
                    id_flush_comb    = 1'b1;
                    ex_flush_comb    = 1'b1;
                    epc_next         = ex_pc;
                    cause_next       = CAUSE_OVF;
                    redirect_pc_next = VEC_OVF;
                    state_next       = ST_REDIRECT;
                end else if (drain_cnt_reg == '0) begin
                    halted_next = 1'b1;
                    state_next  = ST_HALTED;
                end else begin
                    drain_cnt_next = drain_cnt_reg - CNT_W'(1);
                end
            end

            ST_HALTED: begin
                pc_write_en_comb = 1'b0;
                if_flush_comb    = 1'b1;
                if (resume) begin
                    halted_next = 1'b0;
                    cause_next  = CAUSE_NONE;
                    state_next  = ST_RUN;
                end
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // State and captured exception registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_RUN;
            epc_reg         <= '0;
            redirect_pc_reg <= '0;
            cause_reg       <= CAUSE_NONE;
            halted_reg      <= 1'b0;
            drain_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            epc_reg         <= epc_next;
            redirect_pc_reg <= redirect_pc_next;
            cause_reg       <= cause_next;
            halted_reg      <= halted_next;
            drain_cnt_reg   <= drain_cnt_next;
        end
    end

    // While reset is held the pipeline runs freely, whatever the inputs say.
    assign if_flush    = reset & if_flush_comb;
    assign id_flush    = reset & id_flush_comb;
    assign ex_flush    = reset & ex_flush_comb;
    assign pc_redirect = reset & pc_redirect_comb;
    assign pc_write_en = ~reset | pc_write_en_comb;

    assign redirect_pc = redirect_pc_reg;
    assign epc         = epc_reg;
    assign cause       = cause_reg;
    assign halted      = halted_reg;

`ifdef PIPE_EXC_COUNT_EN
    logic [7:0] exc_count_reg;
    logic       exc_take;

    // Accepted illegal/overflow events; halts do not count.
    assign exc_take = ((state_reg == ST_RUN) && (ex_overflow || id_illegal)) ||
                      ((state_reg == ST_DRAIN) && ex_overflow);

    // Saturating exception counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exc_count_reg <= '0;
        end else if (exc_take && (exc_count_reg != 8'hFF)) begin
            exc_count_reg <= exc_count_reg + 8'd1;
        end
    end

    assign exc_count = exc_count_reg;
`endif

endmodule

// File: doc/pipe_exc_ctrl.md
# pipe_exc_ctrl

Exception and halt sequencer for the 16-bit five-stage CPU pipeline. It watches the illegal-opcode flag in ID, the arithmetic-overflow flag in EX and the decoded halt bit, then drives the stage flush lines, the PC write-enable and PC redirect. It also captures the exception PC (EPC) and Cause. It sits beside the hazard unit inside `cpu` and owns every pipeline flush and stall that is not a data hazard.

## Interface
Parameters:
- `PC_W`, 16: PC / EPC width.
- `VEC_ILLEGAL`, 16'h8000: handler address for an illegal opcode.
- `VEC_OVF`, 16'h8010: handler address for an arithmetic overflow.
- `DRAIN_CYCLES`, 3: cycles waited after a halt so older instructions in EX, MEM and WB retire.

Ports:
- `clock` in 1: pipeline clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `id_illegal` in 1: the instruction in ID has an undefined opcode.
- `id_halt` in 1: the instruction in ID is HALT.
- `id_pc` in PC_W: PC of the instruction in ID.
- `ex_overflow` in 1: the ALU result in EX overflowed.
- `ex_pc` in PC_W: PC of the instruction in EX.
- `resume` in 1: single-cycle pulse that leaves the halted state.
- `if_flush` out 1: zero the IF/ID buffer at the next edge.
- `id_flush` out 1: zero the ID/EX control fields.
- `ex_flush` out 1: zero the EX/MEM control fields.
- `pc_write_en` out 1: PC register may update.
- `pc_redirect` out 1: PC loads `redirect_pc` instead of PC+2.
- `redirect_pc` out PC_W: handler vector.
- `epc` out PC_W: captured exception PC.
- `cause` out 2: 00 none, 01 illegal, 10 overflow, 11 halt.
- `halted` out 1: the core is stopped.

## Operation
States: RUN, REDIRECT, DRAIN, HALTED.

Flush and stall outputs are combinational from the state and the current inputs. `epc`, `cause`, `halted` and the state are registered.

RUN:
- **Overflow.** If `ex_overflow` is set, drive `if_flush`, `id_flush` and `ex_flush` to 1 in the same cycle. At the edge: `epc<=ex_pc`, `cause<=10`, `redirect_pc<=VEC_OVF`, state goes to REDIRECT. Overflow always takes priority over ID events, because it belongs to the older instruction.
- **Illegal opcode.** Otherwise, if `id_illegal` is set, drive `if_flush` and `id_flush` to 1. At the edge: `epc<=id_pc`, `cause<=01`, `redirect_pc<=VEC_ILLEGAL`, state goes to REDIRECT.
- **Halt.** Otherwise, if `id_halt` is set, drive `if_flush` and `id_flush` to 1 and `pc_write_en` to 0. At the edge: `epc<=id_pc`, `cause<=11`, the drain counter is loaded with DRAIN_CYCLES−1, state goes to DRAIN.
- **Normal.** Otherwise all flushes are 0 and `pc_write_en` is 1.

REDIRECT:
- `pc_redirect=1`, `pc_write_en=1`, `if_flush=1` for exactly one cycle, then RUN.
- `ex_overflow` in this cycle is ignored; the instruction was already flushed.

DRAIN:
- `pc_write_en=0`, `if_flush=1`.
- An `ex_overflow` in DRAIN abandons the halt and takes the full overflow path from RUN, overwriting `epc` and `cause`.
- When the counter reaches 0, state goes to HALTED and `halted<=1`.

HALTED:
- `pc_write_en=0`, `if_flush=1`.
- `resume` sets `halted<=0`, clears `cause` to 00 and returns to RUN. `pc_write_en` becomes 1 in the next cycle, and fetch restarts at the PC after the HALT.

`cause` and `epc` otherwise hold their values until the next event.

## Timing
- Reset (`reset=0`, asynchronous) sets: state RUN, `epc=0`, `cause=00`, `halted=0`, `redirect_pc=0`, drain counter 0.
- Outputs while reset is asserted: `pc_write_en=1`, `pc_redirect=0`, all flushes 0. A reset in the middle of REDIRECT, DRAIN or HALTED aborts the sequence.
- Exception to redirect latency: the flag is seen in cycle N, flushes are driven in cycle N, and `pc_redirect` is high in cycle N+1. The handler's first instruction is in IF in cycle N+2.
- Halt to `halted` latency: DRAIN_CYCLES+1 edges after the cycle in which `id_halt` is seen.
- `ex_overflow` together with `id_illegal` or `id_halt` in the same cycle: only the overflow is recorded.
- `resume` outside HALTED is ignored.

## Configuration
- Macro `PIPE_EXC_COUNT_EN`.
- Defined: adds output port `exc_count` (8 bits, reset 0). It increments on each accepted illegal or overflow event and saturates at 8'hFF. Halts are not counted.
- Undefined: the port and the counter logic are absent.

## Test plan
- **Overflow.** `ex_overflow=1`, `ex_pc=16'h0024` in RUN -> all three flushes 1 that cycle; next cycle `pc_redirect=1`, `redirect_pc=16'h8010`, `epc=16'h0024`, `cause=10`.
- **Illegal opcode.** `id_illegal=1`, `id_pc=16'h0030` -> `if_flush=id_flush=1`, `ex_flush=0`; next cycle `redirect_pc=16'h8000`, `cause=01`, `epc=16'h0030`.
- **Simultaneous events.** `ex_overflow` and `id_illegal` in the same cycle with `ex_pc=16'h0010`, `id_pc=16'h0012` -> `cause=10`, `epc=16'h0010`.
- **Halt and resume.** `id_halt=1` at `id_pc=16'h0040` -> `pc_write_en=0` from that cycle; `halted=1` after 4 edges, `cause=11`; a `resume` pulse -> `halted=0`, `cause=00`, `pc_write_en=1` the following cycle.
- **Overflow during drain.** Assert `ex_overflow` in the second DRAIN cycle -> REDIRECT to 16'h8010, `halted` never rises.
- **Reset mid-halt.** Drive `reset` low while HALTED, asynchronously and between clock edges -> `halted=0`, `epc=0`, `cause=00` immediately; with `PIPE_EXC_COUNT_EN` defined, `exc_count=0`.
